// File: rtl/sobel_window_gen_pkg.sv
// sobel_pkg: shared defaults, FSM state encoding and pixel type for the Sobel window generator.
// Consumed by sobel_window_gen, its interface and its line buffers.
package sobel_pkg;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 256;
    typedef enum logic [1:0] {IDLE, ROW, PAD_COL, PAD_ROW} win_state_t;
    typedef logic [DEF_PIX_W-1:0] pix_t;
endpackage

// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel-in / window-out bundle; master drives pixels, slave is the generator.
// With SOBEL_WIN_COORD_EN the bundle also carries the window-centre coordinates win_x/win_y.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
);
    logic             in_valid, in_sof, in_ready, win_valid, win_eof;
    logic [PIX_W-1:0] in_pixel, p00, p01, p02, p10, p11, p12, p20, p21, p22;
`ifdef SOBEL_WIN_COORD_EN
    logic [$clog2(IMG_W)-1:0] win_x;
    logic [$clog2(IMG_H)-1:0] win_y;
`endif
    modport master (
        output in_valid, in_sof, in_pixel,
        input  in_ready, win_valid, win_eof,
`ifdef SOBEL_WIN_COORD_EN
        win_x, win_y,
`endif
        p00, p01, p02, p10, p11, p12, p20, p21, p22
    );
    modport slave (
        input  in_valid, in_sof, in_pixel,
        output in_ready, win_valid, win_eof,
`ifdef SOBEL_WIN_COORD_EN
        win_x, win_y,
`endif
        p00, p01, p02, p10, p11, p12, p20, p21, p22
    );
endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// line_buffer: single-port row store of DEPTH entries, written in place with a same-address
// combinational read so the old row value is available in the cycle it is overwritten.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DEPTH = DEF_IMG_W + 1
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [PIX_W-1:0]         wdata_i,
    output logic [PIX_W-1:0]         rdata_o
);
    logic [PIX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 zero-padded window generator feeding sobel_operator.
// Optional SOBEL_WIN_COORD_EN adds registered window-centre coordinates win_x/win_y.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_PAD  = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PAD  = RW'(IMG_H);

    win_state_t            state_q, state_d;
    logic [CW-1:0]         col_q, col_d, pc;
    logic [RW-1:0]         row_q, row_d, pr;
    logic [PIX_W-1:0]      pv, lb1_rd, lb2_rd;
    logic [1:0][PIX_W-1:0] top_q, mid_q, bot_q;
    logic [8:0][PIX_W-1:0] win_q, win_d;
    logic                  acc, proc, emit, mask_r, mask_c, valid_q, eof_q;

    assign bus.in_ready = (state_q == IDLE) || (state_q == ROW);
    assign acc          = bus.in_valid && bus.in_ready;

    // Each cycle processes at most one virtual-grid pixel (pr, pc, pv); pads carry a zero.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        proc    = 1'b0;
        pr      = row_q;
        pc      = col_q;
        pv      = bus.in_pixel;
        if (acc && bus.in_sof) begin
            proc    = 1'b1;
            pr      = '0;
            pc      = '0;
            state_d = ROW;
            col_d   = CW'(1);
            row_d   = '0;
        end else begin
            case (state_q)
                ROW: if (acc) begin
                    proc    = 1'b1;
                    state_d = (col_q == COL_LAST) ? PAD_COL : ROW;
                    col_d   = col_q + CW'(1);
                end
                PAD_COL: begin
                    proc    = 1'b1;
                    pv      = '0;
                    state_d = (row_q == ROW_LAST) ? PAD_ROW : ROW;
                    row_d   = (row_q == ROW_LAST) ? ROW_PAD : row_q + RW'(1);
                    col_d   = '0;
                end
                PAD_ROW: begin
                    proc    = 1'b1;
                    pv      = '0;
                    state_d = (col_q == COL_PAD) ? IDLE : PAD_ROW;
                    col_d   = (col_q == COL_PAD) ? '0 : col_q + CW'(1);
                    row_d   = (col_q == COL_PAD) ? '0 : row_q;
                end
                default: ;
            endcase
        end
    end

    line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W + 1)) u_lb1 (
        .clk(clk), .we_i(proc), .addr_i(pc), .wdata_i(pv), .rdata_o(lb1_rd)
    );
    line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W + 1)) u_lb2 (
        .clk(clk), .we_i(proc), .addr_i(pc), .wdata_i(lb1_rd), .rdata_o(lb2_rd)
    );

    // Masking hides left-column and top-row taps, which would otherwise expose stale data.
    assign emit   = proc && (pr != '0) && (pc != '0);
    assign mask_r = pr == RW'(1);
    assign mask_c = pc == CW'(1);

    always_comb begin
        win_d[0] = (mask_r || mask_c) ? '0 : top_q[0];
        win_d[1] = mask_r ? '0 : top_q[1];
        win_d[2] = mask_r ? '0 : lb2_rd;
        win_d[3] = mask_c ? '0 : mid_q[0];
        win_d[4] = mid_q[1];
        win_d[5] = lb1_rd;
        win_d[6] = mask_c ? '0 : bot_q[0];
        win_d[7] = bot_q[1];
        win_d[8] = pv;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= emit;
            eof_q   <= emit && (pr == ROW_PAD) && (pc == COL_PAD);
            if (proc) begin
                top_q <= {lb2_rd, top_q[1]};
                mid_q <= {lb1_rd, mid_q[1]};
                bot_q <= {pv, bot_q[1]};
            end
            if (emit) win_q <= win_d;
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (emit) begin
            x_q <= XW'(pc - CW'(1));
            y_q <= YW'(pr - RW'(1));
        end
    end

    assign bus.win_x = x_q;
    assign bus.win_y = y_q;
`endif

    assign bus.win_valid = valid_q;
    assign bus.win_eof   = eof_q;
    assign bus.p00       = win_q[0];
    assign bus.p01       = win_q[1];
    assign bus.p02       = win_q[2];
    assign bus.p10       = win_q[3];
    assign bus.p11       = win_q[4];
    assign bus.p12       = win_q[5];
    assign bus.p20       = win_q[6];
    assign bus.p21       = win_q[7];
    assign bus.p22       = win_q[8];
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed checks of sobel_window_gen on a 4x3 image, pixel (r,c) = 10r+c+1.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    typedef logic [71:0] w72_t;
    typedef struct {
        pix_t pix;
        bit   sof;
        int   exp_wait;
        bit   row_end;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy_s = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acc_n = 0;
    vec_t vec[12];
    w72_t cap_p[$];
    bit   cap_eof[$];
    int   cap_acc[$];

    sobel_window_gen_if #(.PIX_W(8), .IMG_W(4), .IMG_H(3)) bus ();

    sobel_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic w72_t cur_win();
        return {bus.p22, bus.p21, bus.p20, bus.p12, bus.p11, bus.p10, bus.p02, bus.p01, bus.p00};
    endfunction

    always @(negedge clk) rdy_s <= bus.in_ready;

    always @(negedge clk) begin
        if (rst && bus.win_valid) begin
            cap_p.push_back(cur_win());
            cap_eof.push_back(bus.win_eof);
            cap_acc.push_back(acc_n);
        end
    end

    // Reference image with zero padding outside 3 rows x 4 columns.
    function automatic pix_t ref_pix(input int r, input int c);
        return (r < 0 || r > 2 || c < 0 || c > 3) ? 8'd0 : pix_t'(10 * r + c + 1);
    endfunction

    function automatic w72_t win_at(input int cr, input int cc);
        w72_t w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = ref_pix(cr - 1 + k / 3, cc - 1 + k % 3);
        return w;
    endfunction

    function automatic w72_t w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int   v[9];
        w72_t w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = v[k][7:0];
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input w72_t act, input w72_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input pix_t v, input bit sof, output int w);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = v;
        while (!ok && n < 20) begin
            @(posedge clk);
            ok = rdy_s;
            n++;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        if (ok) acc_n++;
        chk($sformatf("accept px%0d", v), int'(ok), 1);
        w = n - 1;
    endtask

    task automatic gap(input int k);
        bus.in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
            chk("gap no window", int'(bus.win_valid), 0);
        end
    endtask

    task automatic run_frame(input int first_wait, input bit stalls);
        int w;
        for (int i = 0; i < 12; i++) begin
            send(vec[i].pix, vec[i].sof, w);
            if (!stalls)
                chk($sformatf("ready wait px%0d", vec[i].pix), w, i == 0 ? first_wait : vec[i].exp_wait);
            if (stalls && !vec[i].row_end) gap(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic check_frame(input string tag, input int nf);
        int n;
        int j;
        n = 0;
        while (cap_p.size() < 12 * nf && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, " window count"}, cap_p.size(), 12 * nf);
        for (int i = 0; i < cap_p.size() && i < 12 * nf; i++) begin
            j = i % 12;
            chkw($sformatf("%s win%0d", tag, i), cap_p[i], win_at(j / 4, j % 4));
            chk($sformatf("%s eof%0d", tag, i), int'(cap_eof[i]), j == 11 ? 1 : 0);
        end
        cap_p.delete();
        cap_eof.delete();
        cap_acc.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        for (int i = 0; i < 12; i++)
            vec[i] = '{pix_t'(10 * (i / 4) + i % 4 + 1), i == 0, (i % 4 == 0 && i > 0) ? 1 : 0, i % 4 == 3};

        // Reset held with random inputs.
        repeat (5) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom);
            bus.in_sof   = 1'($urandom);
            bus.in_pixel = 8'($urandom);
            @(negedge clk);
            chk("reset win_valid", int'(bus.win_valid), 0);
            chk("reset in_ready", int'(bus.in_ready), 1);
            chkw("reset window", cur_win(), '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;

        // Pixels without a start of frame are discarded.
        for (int i = 0; i < 6; i++) send(vec[i].pix, 1'b0, w);
        gap(6);
        chk("no-sof window count", cap_p.size(), 0);
        chk("no-sof in_ready", int'(bus.in_ready), 1);

        // Two clean frames back to back: second sof waits out PAD_COL + PAD_ROW.
        acc_n = 0;
        run_frame(0, 1'b0);
        run_frame(6, 1'b0);
        if (cap_p.size() >= 12) begin
            chkw("first window", cap_p[0], w9(0, 0, 0, 0, 1, 2, 0, 11, 12));
            chk("first window after pixel", cap_acc[0], 6);
            chkw("last window", cap_p[11], w9(13, 14, 0, 23, 24, 0, 0, 0, 0));
            chk("last window eof", int'(cap_eof[11]), 1);
        end else begin
            chk("frame1 windows present", cap_p.size(), 12);
        end
        check_frame("clean", 2);

        // Random input gaps.
        run_frame(0, 1'b1);
        check_frame("stall", 1);

        // Mid-frame restart on the 7th pixel.
        for (int i = 0; i < 6; i++) send(vec[i].pix, vec[i].sof, w);
        gap(1);
        cap_p.delete();
        cap_eof.delete();
        cap_acc.delete();
        run_frame(0, 1'b0);
        check_frame("restart", 1);

        // Asynchronous reset during PAD_COL right after a window was emitted.
        for (int i = 0; i < 8; i++) send(vec[i].pix, vec[i].sof, w);
        #2;
        chk("pre-reset in_ready", int'(bus.in_ready), 0);
        chk("pre-reset win_valid", int'(bus.win_valid), 1);
        rst = 1'b0;
        #1;
        chk("async reset win_valid", int'(bus.win_valid), 0);
        chk("async reset win_eof", int'(bus.win_eof), 0);
        chk("async reset in_ready", int'(bus.in_ready), 1);
        chkw("async reset window", cur_win(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cap_p.delete();
        cap_eof.delete();
        cap_acc.delete();
        run_frame(0, 1'b0);
        check_frame("post-reset", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
